// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
// Holds the FSM encoding, the port identifiers and the default bus geometry.
package mem_bus_arbiter_pkg;

   localparam int ARB_ADDR_WIDTH      = 32;
   localparam int ARB_DATA_WIDTH      = 32;
   localparam int ARB_SEL_WIDTH       = ARB_DATA_WIDTH / 8;
   localparam int ARB_TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_INST = 1'b0,
      PORT_DATA = 1'b1
   } arb_port_t;

   // Counter width able to hold the value 'limit' itself (at least one bit).
   function automatic int timeout_counter_width(input int limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout_counter.sv
// Saturating wait-cycle counter used to detect a hung bus transfer.
// 'expired' compares the current count, so a limit of N allows N+1 waiting cycles.
module bus_timeout_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] limit,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clock) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != {WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

   // A zero limit disables expiry entirely.
   assign expired = (limit != '0) && (count >= limit);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises instruction-fetch and data accesses onto one external memory bus,
// pulses per-port acknowledges, stalls the pipeline and aborts hung transfers.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
   parameter int DATA_WIDTH = ARB_DATA_WIDTH,
   parameter int SEL_WIDTH  = ARB_SEL_WIDTH,
   parameter int TIMEOUT    = ARB_TIMEOUT_DEFAULT
) (
   input  logic                  clock,
   input  logic                  reset,

   input  logic                  inst_req,
   input  logic [ADDR_WIDTH-1:0] inst_addr,
   output logic                  inst_ack,
   output logic [DATA_WIDTH-1:0] inst_data,

   input  logic                  data_req,
   input  logic                  data_we,
   input  logic [SEL_WIDTH-1:0]  data_sel,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [DATA_WIDTH-1:0] data_wdata,
   output logic                  data_ack,
   output logic [DATA_WIDTH-1:0] data_rdata,

   output logic                  bus_req,
   output logic                  bus_we,
   output logic [SEL_WIDTH-1:0]  bus_sel,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic                  bus_ack,
   input  logic [DATA_WIDTH-1:0] bus_rdata,

   output logic                  stall_request,
   output logic                  bus_error,
   output logic [ADDR_WIDTH-1:0] error_addr
);

   localparam int CNT_WIDTH = timeout_counter_width(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT);

   arb_state_t state;
   arb_state_t state_next;
   arb_port_t  grant_port;
   arb_port_t  pick_port;
   logic       inst_owed;
   logic       start_grant;
   logic       finish_ack;
   logic       finish_timeout;
   logic       timer_clear;
   logic       timer_enable;
   logic       timer_expired;

   bus_timeout_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_timeout (
      .clock   (clock),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .limit   (CNT_LIMIT),
      .expired (timer_expired)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Data wins a collision unless it already won the last one while fetch waited.
   always_comb begin
      state_next     = state;
      pick_port      = PORT_DATA;
      start_grant    = 1'b0;
      finish_ack     = 1'b0;
      finish_timeout = 1'b0;
      timer_clear    = 1'b0;
      timer_enable   = 1'b0;

      if (inst_req && data_req) begin
         pick_port = inst_owed ? PORT_INST : PORT_DATA;
      end else if (inst_req) begin
         pick_port = PORT_INST;
      end

      case (state)
         ARB_IDLE: begin
            if (inst_req || data_req) begin
               start_grant = 1'b1;
               timer_clear = 1'b1;
               state_next  = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (bus_ack) begin
               finish_ack = 1'b1;
               state_next = ARB_DONE;
            end else if (timer_expired) begin
               finish_timeout = 1'b1;
               state_next     = ARB_DONE;
            end else begin
               timer_enable = 1'b1;
            end
         end
         ARB_DONE: begin
            state_next = ARB_IDLE;
         end
         default: begin
            state_next = ARB_IDLE;
         end
      endcase
   end

   // Fetches are full-word reads, so they drive all byte lanes and no write data.
   always_ff @(posedge clock) begin
      if (!reset) begin
         grant_port <= PORT_INST;
         inst_owed  <= 1'b0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_sel    <= '0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         inst_ack   <= 1'b0;
         inst_data  <= '0;
         data_ack   <= 1'b0;
         data_rdata <= '0;
         bus_error  <= 1'b0;
         error_addr <= '0;
      end else begin
         inst_ack  <= 1'b0;
         data_ack  <= 1'b0;
         bus_error <= 1'b0;

         if (start_grant) begin
            grant_port <= pick_port;
            bus_req    <= 1'b1;
            if (pick_port == PORT_DATA) begin
               bus_we    <= data_we;
               bus_sel   <= data_sel;
               bus_addr  <= data_addr;
               bus_wdata <= data_wdata;
               inst_owed <= inst_req;
            end else begin
               bus_we    <= 1'b0;
               bus_sel   <= '1;
               bus_addr  <= inst_addr;
               bus_wdata <= '0;
               inst_owed <= 1'b0;
            end
         end

         if (finish_ack || finish_timeout) begin
            bus_req <= 1'b0;
            if (grant_port == PORT_DATA) begin
               data_ack   <= 1'b1;
               data_rdata <= (finish_ack && !bus_we) ? bus_rdata : '0;
            end else begin
               inst_ack  <= 1'b1;
               inst_data <= finish_ack ? bus_rdata : '0;
            end
            if (finish_timeout) begin
               bus_error  <= 1'b1;
               error_addr <= bus_addr;
            end
         end
      end
   end

   assign stall_request = (inst_req & ~inst_ack) | (data_req & ~data_ack);

endmodule
